// File: rtl/cpu_fwd_pkg.sv
// Operand-bypass select encodings shared by the hazard controller and the EX operand muxes.
package cpu_fwd_pkg;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF    = 2'b00;
   localparam fwd_sel_t FWD_MEMWB = 2'b01;
   localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage : cpu_fwd_pkg

// File: rtl/fwd_src_match.sv
// Per-source dependence check against the EX and MEM destinations: hazard flag and next bypass select.
module fwd_src_match
   import cpu_fwd_pkg::*;
#(
   parameter int unsigned AW         = 4,
   parameter bit          FWD_EX_MEM = 1'b0,
   parameter bit          ZERO_REG   = 1'b1
) (
   input  logic [AW-1:0] src_addr,
   input  logic          src_vld,
   input  logic          ex_wr_en,
   input  logic [AW-1:0] ex_wr_addr,
   input  logic          ex_is_load,
   input  logic          mem_wr_en,
   input  logic [AW-1:0] mem_wr_addr,
   output logic          haz_c,
   output fwd_sel_t      next_sel_c
);

   logic src_live;
   logic hit_ex;
   logic hit_mem;

   // A hardwired zero register never carries a real dependence.
   assign src_live = src_vld & ~(ZERO_REG & (src_addr == '0));
   assign hit_ex   = src_live & ex_wr_en  & (ex_wr_addr  == src_addr);
   assign hit_mem  = src_live & mem_wr_en & (mem_wr_addr == src_addr);

   assign haz_c = hit_ex & (ex_is_load | ~FWD_EX_MEM);

   // Youngest producer wins: an EX hit masks any older MEM hit.
   always_comb begin
      next_sel_c = FWD_RF;
      if (hit_ex & FWD_EX_MEM & ~ex_is_load) begin
         next_sel_c = FWD_EXMEM;
      end else if (hit_mem & ~hit_ex) begin
         next_sel_c = FWD_MEMWB;
      end
   end

endmodule : fwd_src_match

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use hazard controller: registered bypass selects, EX bubble,
// combinational ID stall and a saturating stall counter.
module hazard_forward_ctrl
   import cpu_fwd_pkg::*;
#(
   parameter int unsigned AW         = 4,
   parameter int unsigned NUM_SRC    = 2,
   parameter bit          FWD_EX_MEM = 1'b0,
   parameter bit          ZERO_REG   = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SRC*AW-1:0]  id_src_addr,
   input  logic [NUM_SRC-1:0]     id_src_vld,
   input  logic                   ex_wr_en,
   input  logic [AW-1:0]          ex_wr_addr,
   input  logic                   ex_is_load,
   input  logic                   mem_wr_en,
   input  logic [AW-1:0]          mem_wr_addr,
   input  logic                   mem_stall,
   input  logic                   flush,
   output logic [NUM_SRC*2-1:0]   fwd_sel,
   output logic                   stall_id,
   output logic                   ex_bubble,
   output logic [CNT_W-1:0]       stall_cnt
);

   localparam int unsigned SEL_W = NUM_SRC * 2;

   logic [NUM_SRC-1:0] haz_c;
   logic [SEL_W-1:0]   next_sel_c;
   logic               lu_haz_c;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_sel_t sel_c;

      fwd_src_match #(
         .AW         (AW),
         .FWD_EX_MEM (FWD_EX_MEM),
         .ZERO_REG   (ZERO_REG)
      ) u_match (
         .src_addr    (id_src_addr[g*AW +: AW]),
         .src_vld     (id_src_vld[g]),
         .ex_wr_en    (ex_wr_en),
         .ex_wr_addr  (ex_wr_addr),
         .ex_is_load  (ex_is_load),
         .mem_wr_en   (mem_wr_en),
         .mem_wr_addr (mem_wr_addr),
         .haz_c       (haz_c[g]),
         .next_sel_c  (sel_c)
      );

      assign next_sel_c[g*2 +: 2] = sel_c;
   end

   assign lu_haz_c = |haz_c;
   // A squashed ID instruction cannot cause a stall.
   assign stall_id = lu_haz_c & ~flush;

   // Cache-miss freeze outranks flush, which outranks the load-use bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_sel   <= '0;
         ex_bubble <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (!mem_stall) begin
            if (flush || stall_id) begin
               fwd_sel   <= '0;
               ex_bubble <= 1'b1;
            end else begin
               fwd_sel   <= next_sel_c;
               ex_bubble <= 1'b0;
            end
         end
         if ((stall_id || mem_stall) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule : hazard_forward_ctrl

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (no EX/MEM bypass with a 4-bit counter, and bypass with a 16-bit counter).
module tb_hazard_forward_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] id_src_addr;
   logic [1:0] id_src_vld;
   logic       ex_wr_en;
   logic [3:0] ex_wr_addr;
   logic       ex_is_load;
   logic       mem_wr_en;
   logic [3:0] mem_wr_addr;
   logic       mem_stall;
   logic       flush;

   logic [3:0]  fwd_sel0, fwd_sel1;
   logic        stall_id0, stall_id1;
   logic        ex_bubble0, ex_bubble1;
   logic [3:0]  stall_cnt0;
   logic [15:0] stall_cnt1;

   int n_chk = 0;
   int n_err = 0;

   // Model state, index 0 = no-bypass instance, 1 = bypass instance.
   int m_sel [2][2];
   int m_bub [2];
   int m_cnt [2];

   always #5 clk = ~clk;

   hazard_forward_ctrl #(.AW(4), .NUM_SRC(2), .FWD_EX_MEM(1'b0), .ZERO_REG(1'b1), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_stall(mem_stall), .flush(flush),
      .fwd_sel(fwd_sel0), .stall_id(stall_id0), .ex_bubble(ex_bubble0), .stall_cnt(stall_cnt0)
   );

   hazard_forward_ctrl #(.AW(4), .NUM_SRC(2), .FWD_EX_MEM(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_vld(id_src_vld),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_stall(mem_stall), .flush(flush),
      .fwd_sel(fwd_sel1), .stall_id(stall_id1), .ex_bubble(ex_bubble1), .stall_cnt(stall_cnt1)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int src_of(input int i);
      logic [7:0] a;
      a = id_src_addr;
      return int'(a[i*4 +: 4]);
   endfunction

   // Does source i depend on the EX / MEM destination? (r0 never does)
   function automatic bit dep_ex(input int i);
      return id_src_vld[i] && ex_wr_en && int'(ex_wr_addr) == src_of(i) && src_of(i) != 0;
   endfunction

   function automatic bit dep_mem(input int i);
      return id_src_vld[i] && mem_wr_en && int'(mem_wr_addr) == src_of(i) && src_of(i) != 0;
   endfunction

   function automatic bit m_stall(input bit fwd);
      bit s = 0;
      for (int i = 0; i < 2; i++)
         if (dep_ex(i) && (ex_is_load || !fwd)) s = 1;
      return s && !flush;
   endfunction

   function automatic int m_next(input bit fwd, input int i);
      if (dep_ex(i)) return (fwd && !ex_is_load) ? 2 : 0;
      if (dep_mem(i)) return 1;
      return 0;
   endfunction

   // Reference model of the registered outputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_sel[k][0] = 0; m_sel[k][1] = 0; m_bub[k] = 0; m_cnt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit st;
            int cmax;
            st   = m_stall(k == 1);
            cmax = (k == 1) ? 65535 : 15;
            if (!mem_stall) begin
               for (int i = 0; i < 2; i++)
                  m_sel[k][i] = (flush || st) ? 0 : m_next(k == 1, i);
               m_bub[k] = (flush || st) ? 1 : 0;
            end
            if ((st || mem_stall) && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("dut0.fwd_sel0", int'(fwd_sel0[1:0]), m_sel[0][0]);
      chk("dut0.fwd_sel1", int'(fwd_sel0[3:2]), m_sel[0][1]);
      chk("dut1.fwd_sel0", int'(fwd_sel1[1:0]), m_sel[1][0]);
      chk("dut1.fwd_sel1", int'(fwd_sel1[3:2]), m_sel[1][1]);
      chk("dut0.ex_bubble", int'(ex_bubble0), m_bub[0]);
      chk("dut1.ex_bubble", int'(ex_bubble1), m_bub[1]);
      chk("dut0.stall_cnt", int'(stall_cnt0), m_cnt[0]);
      chk("dut1.stall_cnt", int'(stall_cnt1), m_cnt[1]);
      chk("dut0.stall_id", int'(stall_id0), rst_n ? int'(m_stall(1'b0)) : int'(m_stall(1'b0)));
      chk("dut1.stall_id", int'(stall_id1), int'(m_stall(1'b1)));
   end

   task automatic idle();
      id_src_addr = '0; id_src_vld = '0;
      ex_wr_en = 0; ex_wr_addr = '0; ex_is_load = 0;
      mem_wr_en = 0; mem_wr_addr = '0; mem_stall = 0; flush = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int cnt_before;

   initial begin
      rst_n = 1'b0;
      idle();
      cyc(); cyc();
      chk("reset fwd_sel", int'(fwd_sel1), 0);
      chk("reset ex_bubble", int'(ex_bubble1), 0);
      chk("reset stall_cnt", int'(stall_cnt1), 0);
      rst_n = 1'b1;
      cyc();

      // 1/2: ADD r3 in EX, ID reads r3 on src0
      ex_wr_en = 1; ex_wr_addr = 4'd3; id_src_addr = 8'h03; id_src_vld = 2'b01;
      #1;
      chk("t1 bypass stall_id", int'(stall_id1), 0);
      chk("t2 nobypass stall_id", int'(stall_id0), 1);
      cyc();
      chk("t1 fwd_sel exmem", int'(fwd_sel1[1:0]), 2);
      chk("t2 ex_bubble", int'(ex_bubble0), 1);
      ex_wr_en = 0; mem_wr_en = 1; mem_wr_addr = 4'd3;
      #1;
      chk("t2 retry stall_id", int'(stall_id0), 0);
      cyc();
      chk("t2 retry fwd_sel memwb", int'(fwd_sel0[1:0]), 1);
      chk("t2 stall_cnt", int'(stall_cnt0), 1);

      // 3: LW r5 in EX, src1 reads r5
      idle();
      ex_wr_en = 1; ex_wr_addr = 4'd5; ex_is_load = 1; id_src_addr = 8'h50; id_src_vld = 2'b10;
      #1;
      chk("t3 load stall_id", int'(stall_id1), 1);
      cyc();
      chk("t3 ex_bubble", int'(ex_bubble1), 1);
      ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 1; mem_wr_addr = 4'd5;
      cyc();
      chk("t3 fwd_sel src1 memwb", int'(fwd_sel1[3:2]), 1);

      // 4: EX and MEM both write r2, both sources read r2
      idle();
      ex_wr_en = 1; ex_wr_addr = 4'd2; mem_wr_en = 1; mem_wr_addr = 4'd2;
      id_src_addr = 8'h22; id_src_vld = 2'b11;
      cyc();
      chk("t4 youngest wins", int'(fwd_sel1), 4'b1010);
      ex_wr_addr = 4'd0; mem_wr_addr = 4'd0; id_src_addr = 8'h00;
      #1;
      chk("t4 r0 stall_id", int'(stall_id0), 0);
      cyc();
      chk("t4 r0 fwd_sel", int'(fwd_sel1), 0);

      // 5: load-use hazard, then mem_stall held 3 cycles
      idle();
      ex_wr_en = 1; ex_wr_addr = 4'd5; ex_is_load = 1; id_src_addr = 8'h05; id_src_vld = 2'b01;
      cyc();
      cnt_before = int'(stall_cnt1);
      mem_stall = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5 stall_id held", int'(stall_id1), 1);
         cyc();
         chk("t5 ex_bubble held", int'(ex_bubble1), 1);
         chk("t5 fwd_sel held", int'(fwd_sel1), 0);
      end
      chk("t5 stall_cnt +3", int'(stall_cnt1) - cnt_before, 3);
      mem_stall = 0;

      // 6: flush together with load-use hazard
      idle();
      mem_wr_en = 1; mem_wr_addr = 4'd7; id_src_addr = 8'h75; id_src_vld = 2'b11;
      cyc();
      ex_wr_en = 1; ex_wr_addr = 4'd5; ex_is_load = 1; flush = 1;
      #1;
      chk("t6 flush stall_id", int'(stall_id1), 0);
      cyc();
      chk("t6 flush ex_bubble", int'(ex_bubble1), 1);
      chk("t6 flush fwd_sel", int'(fwd_sel1), 0);

      // Asynchronous reset in the middle of a stall
      flush = 0;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst ex_bubble", int'(ex_bubble1), 0);
      chk("async rst stall_cnt", int'(stall_cnt1), 0);
      chk("async rst fwd_sel", int'(fwd_sel0), 0);
      cyc();
      rst_n = 1'b1;
      idle();

      // Counter saturation on the 4-bit instance
      mem_stall = 1;
      for (int c = 0; c < 20; c++) cyc();
      chk("saturate stall_cnt", int'(stall_cnt0), 15);
      cyc();
      chk("saturate no wrap", int'(stall_cnt0), 15);
      mem_stall = 0;

      // Mixed vectors checked by the model only
      for (int c = 0; c < 60; c++) begin
         id_src_addr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         id_src_vld  = 2'($urandom_range(0, 3));
         ex_wr_en    = 1'($urandom_range(0, 1));
         ex_wr_addr  = 4'($urandom_range(0, 3));
         ex_is_load  = 1'($urandom_range(0, 1));
         mem_wr_en   = 1'($urandom_range(0, 1));
         mem_wr_addr = 4'($urandom_range(0, 3));
         mem_stall   = ($urandom_range(0, 5) == 0);
         flush       = ($urandom_range(0, 5) == 0);
         cyc();
      end
      idle();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule : tb_hazard_forward_ctrl
